idwt53_lifting_inv: RTL and testbench

- Inverse 5/3 (Le Gall) integer lifting stage: the reconstruction end of the forward DWT `top`.
- Consumes one (coarse, detail) coefficient pair per handshake and emits reconstructed samples serially, one per cycle, in natural order x0, x1, x2, …
- Frame boundaries use symmetric extension, matching the forward transform.
- Sits after the coefficient path; output is bit-exact to the forward block's input stream.

---
 rtl/idwt53_lifting_inv.sv | 165 ++++++++++++++++
 tb/tb_idwt53_lifting_inv.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idwt53_lifting_inv.sv
// Inverse 5/3 (Le Gall) integer lifting stage: (coarse, detail) pairs in, samples out in natural order.
// Optional build macro IDWT53_SAT_EN: clamp results instead of wrapping and expose a sticky sat_flag.
module idwt53_lifting_inv #(
  parameter int DATA_W = 16,
  parameter int INT_W  = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] coarse_coefficient,
  input  logic signed [DATA_W-1:0] detail_coefficient,
  input  logic                     last_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     valid_out,
  output logic                     last_out
`ifdef IDWT53_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  typedef enum logic [1:0] {ST_FIRST, ST_RUN, ST_FLUSH} state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic                     last;
  } entry_t;

`ifdef IDWT53_SAT_EN
  localparam logic signed [INT_W-1:0] MAX_I = INT_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [INT_W-1:0] MIN_I = -MAX_I - INT_W'(1);

  function automatic logic clamps(input logic signed [INT_W-1:0] v);
    return (v > MAX_I) || (v < MIN_I);
  endfunction
`endif

  function automatic logic signed [DATA_W-1:0] fit(input logic signed [INT_W-1:0] v);
`ifdef IDWT53_SAT_EN
    if (v > MAX_I) return DATA_W'(MAX_I);
    if (v < MIN_I) return DATA_W'(MIN_I);
    return DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction

  state_t state, state_next;
  logic [1:0] count, count_next, cnt_after_pop, n_push;
  entry_t q [2];
  entry_t q_next [2];
  entry_t push_a, push_b;
  logic signed [DATA_W-1:0] d_prev, e_prev;

  logic accept, flush_push;
  logic signed [INT_W-1:0] s_ext, d_ext, dp_ext, ep_ext, d_left, e_ext;
  logic signed [INT_W-1:0] sum_d, sum_e, e_full, o_full, t_full;
  logic signed [DATA_W-1:0] e_val, o_val, t_val;

  assign in_ready   = (count <= 2'd1) && (state != ST_FLUSH);
  assign accept     = valid_in && in_ready;
  assign flush_push = (state == ST_FLUSH) && (count <= 2'd1);

  // The first pair of a frame mirrors d[-1] onto d[0]; the tail mirrors e[N] onto e[N-1].
  assign s_ext  = INT_W'(coarse_coefficient);
  assign d_ext  = INT_W'(detail_coefficient);
  assign dp_ext = INT_W'(d_prev);
  assign ep_ext = INT_W'(e_prev);
  assign d_left = (state == ST_FIRST) ? d_ext : dp_ext;
  assign sum_d  = d_left + d_ext + INT_W'(2);
  assign e_full = s_ext - (sum_d >>> 2);
  assign e_val  = fit(e_full);
  assign e_ext  = INT_W'(e_val);
  assign sum_e  = ep_ext + e_ext;
  assign o_full = dp_ext + (sum_e >>> 1);
  assign o_val  = fit(o_full);
  assign t_full = dp_ext + ep_ext;
  assign t_val  = fit(t_full);

  always_comb begin
    state_next = state;
    case (state)
      ST_FIRST: if (accept) state_next = last_in ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (accept && last_in) state_next = ST_FLUSH;
      ST_FLUSH: if (count <= 2'd1) state_next = ST_FIRST;
      default:  state_next = ST_FIRST;
    endcase
  end

  // Pop the head first, then append up to two new entries behind whatever remains.
  always_comb begin
    push_a = '{data: '0, last: 1'b0};
    push_b = '{data: '0, last: 1'b0};
    n_push = 2'd0;
    if (flush_push) begin
      push_a = '{data: t_val, last: 1'b1};
      n_push = 2'd1;
    end else if (accept && (state == ST_FIRST)) begin
      push_a = '{data: e_val, last: 1'b0};
      n_push = 2'd1;
    end else if (accept && (state == ST_RUN)) begin
      push_a = '{data: o_val, last: 1'b0};
      push_b = '{data: e_val, last: 1'b0};
      n_push = 2'd2;
    end

    q_next = q;
    cnt_after_pop = count;
    if (count != 2'd0) begin
      q_next[0] = q[1];
      cnt_after_pop = count - 2'd1;
    end
    if (n_push == 2'd2) begin
      q_next[0] = push_a;
      q_next[1] = push_b;
    end else if (n_push == 2'd1) begin
      if (cnt_after_pop == 2'd0) q_next[0] = push_a;
      else q_next[1] = push_a;
    end
    count_next = cnt_after_pop + n_push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FIRST;
      count     <= 2'd0;
      q[0]      <= '{data: '0, last: 1'b0};
      q[1]      <= '{data: '0, last: 1'b0};
      d_prev    <= '0;
      e_prev    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      q         <= q_next;
      valid_out <= (count != 2'd0);
      last_out  <= (count != 2'd0) && q[0].last;
      if (count != 2'd0) data_out <= q[0].data;
      if (accept) begin
        d_prev <= detail_coefficient;
        e_prev <= e_val;
      end
    end
  end

`ifdef IDWT53_SAT_EN
  logic clamp_hit;

  always_comb begin
    clamp_hit = 1'b0;
    if (flush_push) clamp_hit = clamps(t_full);
    else if (accept && (state == ST_FIRST)) clamp_hit = clamps(e_full);
    else if (accept && (state == ST_RUN)) clamp_hit = clamps(e_full) || clamps(o_full);
  end

  always_ff @(posedge clk) begin
    if (rst) sat_flag <= 1'b0;
    else if (clamp_hit) sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_idwt53_lifting_inv.sv
// Bench for idwt53_lifting_inv: constant vector table, hand sequences, and random frames vs a lifting model.
module tb_idwt53_lifting_inv;
  localparam int DATA_W = 16;

  typedef struct packed {
    int               n;
    logic [3:0][15:0] s;
    logic [3:0][15:0] d;
    logic [7:0][15:0] x;
  } vec_t;

  logic clk, rst, valid_in, in_ready, last_in, valid_out, last_out;
  logic signed [DATA_W-1:0] coarse_coefficient, detail_coefficient, data_out;
`ifdef IDWT53_SAT_EN
  logic sat_flag;
`endif

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int first_acc = 0;
  int bad_last = 0;
  shortint fr_s[$];
  shortint fr_d[$];
  bit fr_l[$];
  int exp_q[$];
  bit exp_l[$];
  int out_q[$];
  bit outl_q[$];
  int cyc_q[$];
  bit rdy_hist[int];
  vec_t vecs[$];

  idwt53_lifting_inv #(.DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .in_ready(in_ready),
    .coarse_coefficient(coarse_coefficient),
    .detail_coefficient(detail_coefficient),
    .last_in(last_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .last_out(last_out)
`ifdef IDWT53_SAT_EN
    ,
    .sat_flag(sat_flag)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    rdy_hist[cyc] = in_ready;
    if (valid_out) begin
      out_q.push_back(int'(data_out));
      outl_q.push_back(last_out);
      cyc_q.push_back(cyc);
    end
    if (last_out && !valid_out) bad_last++;
  end

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic int floor_div(input int a, input int b);
    int q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int fit(input int v);
`ifdef IDWT53_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return int'(shortint'(v));
`endif
  endfunction

  // Reference: e[k] from s and neighbouring d, o[k] from d and neighbouring e, mirrored at both ends.
  task automatic model_frame(input int a, input int b);
    int e[$];
    int n = b - a + 1;
    for (int k = 0; k < n; k++) begin
      int dl = fr_d[a + ((k == 0) ? 0 : k - 1)];
      e.push_back(fit(fr_s[a + k] - floor_div(dl + fr_d[a + k] + 2, 4)));
    end
    for (int k = 0; k < n; k++) begin
      int enx = (k == n - 1) ? e[k] : e[k + 1];
      exp_q.push_back(e[k]);
      exp_l.push_back(1'b0);
      exp_q.push_back(fit(fr_d[a + k] + floor_div(e[k] + enx, 2)));
      exp_l.push_back(k == n - 1);
    end
  endtask

  task automatic build_expected();
    int start = 0;
    exp_q.delete();
    exp_l.delete();
    for (int i = 0; i < fr_s.size(); i++) begin
      if (fr_l[i]) begin
        model_frame(start, i);
        start = i + 1;
      end
    end
  endtask

  task automatic push_pair(input shortint s, input shortint d, input bit l);
    fr_s.push_back(s);
    fr_d.push_back(d);
    fr_l.push_back(l);
  endtask

  task automatic clear_all();
    fr_s.delete();
    fr_d.delete();
    fr_l.delete();
    out_q.delete();
    outl_q.delete();
    cyc_q.delete();
  endtask

  task automatic add_vec(input int n, input int s0, s1, s2, s3, input int d0, d1, d2, d3,
                         input int x0, x1, x2, x3, x4, x5, x6, x7);
    vec_t v;
    int sa[4] = '{s0, s1, s2, s3};
    int da[4] = '{d0, d1, d2, d3};
    int xa[8] = '{x0, x1, x2, x3, x4, x5, x6, x7};
    v.n = n;
    for (int i = 0; i < 4; i++) begin
      v.s[i] = sa[i][15:0];
      v.d[i] = da[i][15:0];
    end
    for (int i = 0; i < 8; i++) v.x[i] = xa[i][15:0];
    vecs.push_back(v);
  endtask

  task automatic load_vec(input vec_t v);
    exp_q.delete();
    exp_l.delete();
    for (int i = 0; i < v.n; i++) push_pair(shortint'(v.s[i]), shortint'(v.d[i]), i == v.n - 1);
    for (int i = 0; i < 2 * v.n; i++) begin
      exp_q.push_back(int'(signed'(v.x[i])));
      exp_l.push_back(i == 2 * v.n - 1);
    end
  endtask

  // Called and returns on a falling edge; the pair is held until in_ready lets it through.
  task automatic apply_stimulus(input int gap_max);
    for (int i = 0; i < fr_s.size(); i++) begin
      int gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      int guard = 0;
      if (gap > 0) begin
        valid_in = 1'b0;
        repeat (gap) @(negedge clk);
      end
      valid_in = 1'b1;
      coarse_coefficient = fr_s[i];
      detail_coefficient = fr_d[i];
      last_in = fr_l[i];
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check_output($sformatf("ready_wait%0d", i), int'(guard < 50), 1);
      if (guard >= 50) break;
      @(negedge clk);
      if (i == 0) first_acc = cyc;
    end
    valid_in = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic collect(input int want);
    int guard = 0;
    while (out_q.size() < want && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_capture(input string name);
    check_output({name, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check_output($sformatf("%s_x%0d", name, i), out_q[i], exp_q[i]);
      check_output($sformatf("%s_last%0d", name, i), int'(outl_q[i]), int'(exp_l[i]));
    end
  endtask

  function automatic int count_gaps();
    int g = 0;
    for (int i = 1; i < cyc_q.size(); i++) if (cyc_q[i] != cyc_q[i - 1] + 1) g++;
    return g;
  endfunction

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    last_in = 1'b0;
    coarse_coefficient = '0;
    detail_coefficient = '0;
    repeat (2) @(negedge clk);
    check_output("rst_valid_out", int'(valid_out), 0);
    check_output("rst_last_out", int'(last_out), 0);
    check_output("rst_data_out", int'(data_out), 0);
    check_output("rst_in_ready", int'(in_ready), 1);
`ifdef IDWT53_SAT_EN
    check_output("rst_sat_flag", int'(sat_flag), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    add_vec(4, 2, 7, 12, 19, 2, 0, 1, 4, 1, 5, 6, 9, 12, 16, 18, 22);
    add_vec(1, 2, 0, 0, 0, 2, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    add_vec(1, 5, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0);
    add_vec(2, -3, 4, 0, 0, 5, -2, 0, 0, -6, 3, 3, 1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0, -3, 0, 0, 0, 1, -2, 0, 0, 0, 0, 0, 0);
`ifdef IDWT53_SAT_EN
    add_vec(1, -32768, 0, 0, 0, -32768, 0, 0, 0, -16384, -32768, 0, 0, 0, 0, 0, 0);
`else
    add_vec(1, -32768, 0, 0, 0, -32768, 0, 0, 0, -16384, 16384, 0, 0, 0, 0, 0, 0);
`endif

    for (int v = 0; v < vecs.size(); v++) begin
      clear_all();
      load_vec(vecs[v]);
      apply_stimulus(0);
      collect(exp_q.size());
      compare_capture($sformatf("vec%0d", v));
      check_output($sformatf("vec%0d_latency", v), (cyc_q.size() > 0) ? cyc_q[0] : -1, first_acc + 1);
      check_output($sformatf("vec%0d_gaps", v), count_gaps(), 0);
      if (v == 0)
        for (int k = 0; k < 4; k++)
          check_output($sformatf("nominal_in_ready%0d", k), int'(rdy_hist[first_acc + k]), (k % 2 == 0) ? 1 : 0);
`ifdef IDWT53_SAT_EN
      check_output($sformatf("vec%0d_sat_flag", v), int'(sat_flag), (v == vecs.size() - 1) ? 1 : 0);
`endif
    end

    // Back-to-back frames with valid_in held high: no bubbles and no carry-over.
    clear_all();
    push_pair(2, 2, 0); push_pair(7, 0, 0); push_pair(12, 1, 0); push_pair(19, 4, 1);
    push_pair(5, 0, 1);
    exp_q = '{1, 5, 6, 9, 12, 16, 18, 22, 5, 5};
    exp_l = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    apply_stimulus(0);
    collect(exp_q.size());
    compare_capture("b2b");
    check_output("b2b_gaps", count_gaps(), 0);

    // Nominal frame with random input gaps.
    clear_all();
    push_pair(2, 2, 0); push_pair(7, 0, 0); push_pair(12, 1, 0); push_pair(19, 4, 1);
    exp_q = '{1, 5, 6, 9, 12, 16, 18, 22};
    exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
    apply_stimulus(3);
    collect(exp_q.size());
    compare_capture("gappy");

    // Reset after the second accept, then a fresh single-pair frame.
    clear_all();
    push_pair(2, 2, 0); push_pair(7, 0, 0);
    apply_stimulus(0);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_valid_out", int'(valid_out), 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_valid_out2", int'(valid_out), 0);
    check_output("mid_rst_in_ready", int'(in_ready), 1);
`ifdef IDWT53_SAT_EN
    check_output("mid_rst_sat_flag", int'(sat_flag), 0);
`endif
    clear_all();
    push_pair(2, 2, 1);
    exp_q = '{1, 3};
    exp_l = '{0, 1};
    apply_stimulus(0);
    collect(exp_q.size());
    compare_capture("after_rst");

    // Random frames, sometimes two back-to-back, against the lifting model.
    for (int f = 0; f < 25; f++) begin
      int frames = int'($urandom_range(2, 1));
      clear_all();
      for (int g = 0; g < frames; g++) begin
        int n = int'($urandom_range(6, 1));
        for (int i = 0; i < n; i++)
          push_pair(shortint'($urandom), shortint'($urandom), i == n - 1);
      end
      build_expected();
      apply_stimulus(int'($urandom_range(2, 0)));
      collect(exp_q.size());
      compare_capture($sformatf("rand%0d", f));
    end

    check_output("last_without_valid", bad_last, 0);
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
